// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// Provides the FSM state enum, slice width and index-width helper.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    // Width of the nibble index; never below one bit.
    function automatic int idx_w(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/adder_seq_ctrl_nibble_add4.sv
// Combinational 4-bit adder slice shared by every nibble step.
// Ports: a4, b4, cin in; s4 sum and cout carry out.
module nibble_add4 (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       cin,
    output logic [3:0] s4,
    output logic       cout
);

    assign {cout, s4} = 5'(a4) + 5'(b4) + 5'(cin);

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide adder built from one 4-bit slice, one nibble per clock, LSB first.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a, b,
// c_in, sub; out_valid/out_ready with sum, c_out; busy while running.
// Optional macro ADDER_SUB_EN: sub=1 computes a-b (c_out=1 => no borrow).
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int NIB = WIDTH / NIB_W;
    localparam int IW  = idx_w(NIB);

    state_t state, state_n;

    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;

    logic [IW+1:0]    base;
    logic [3:0]       s4;
    logic             c4;
    logic             last;
    logic             accept;

    logic [WIDTH-1:0] b_ld;
    logic             cin_ld;

`ifdef ADDER_SUB_EN
    // Subtract as a + ~b + 1; the forced carry replaces c_in.
    assign b_ld   = sub ? ~b : b;
    assign cin_ld = sub ? 1'b1 : c_in;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_ld       = b;
    assign cin_ld     = c_in;
`endif

    assign base   = {idx, 2'b00};
    assign last   = (idx == IW'(NIB - 1));
    assign accept = (state == IDLE) && in_valid;

    nibble_add4 u_slice (
        .a4  (op_a[base +: NIB_W]),
        .b4  (op_b[base +: NIB_W]),
        .cin (carry_q),
        .s4  (s4),
        .cout(c4)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (in_valid) state_n = RUN;
            RUN:  if (last) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else if (accept) begin
            // sum_q is left alone; each nibble is overwritten in RUN.
            idx     <= '0;
            op_a    <= a;
            op_b    <= b_ld;
            carry_q <= cin_ld;
        end else if (state == RUN) begin
            sum_q[base +: NIB_W] <= s4;
            carry_q              <= c4;
            idx                  <= last ? '0 : idx + IW'(1);
            if (last) begin
                c_out_q <= c4;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign sum       = sum_q;
    assign c_out     = c_out_q;

endmodule
